vc_arbiter: RTL and testbench

//  Scheduler between the VC0/VC1 input FIFOs and the two downstream destination FIFOs (D0/D1).
//  - Pops the VC FIFOs with weighted priority: VC0 gets up to VC0_WEIGHT consecutive grants,

---
 rtl/vc_arbiter_if.sv | 40 ++++
 rtl/vc_arbiter.sv | 121 ++++++++++++
 tb/tb_vc_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_arbiter_if.sv
// Signal bundle between vc_arbiter and its VC0/VC1 source FIFOs and D0/D1 destination FIFOs.
// The slave modport is the arbiter's view. The master modport is the FIFO/environment view.
interface vc_arbiter_if #(
  parameter int data_width = 6
);
  // Handshake: pop_VCx is a combinational read strobe, so data_out_VCx is valid one cycle later.
  // push_Dx is a registered write strobe qualified only by itself.
  // almost_full_Dx throttles new pops; full_Dx is only observed to flag overflow.
  logic                  empty_fifo_VC0;
  logic                  empty_fifo_VC1;
  logic [data_width-1:0] data_out_VC0;
  logic [data_width-1:0] data_out_VC1;
  logic                  almost_full_D0;
  logic                  almost_full_D1;
  logic                  full_D0;
  logic                  full_D1;
  logic                  pop_VC0_fifo;
  logic                  pop_VC1_fifo;
  logic                  push_D0;
  logic                  push_D1;
  logic [data_width-1:0] data_out_arb;
  logic [1:0]            state;
  logic                  idle;
  logic                  error_arb;
  logic [7:0]            stall_count;

  modport slave (
    input  empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    input  almost_full_D0, almost_full_D1, full_D0, full_D1,
    output pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_arb,
    output state, idle, error_arb, stall_count
  );

  modport master (
    output empty_fifo_VC0, empty_fifo_VC1, data_out_VC0, data_out_VC1,
    output almost_full_D0, almost_full_D1, full_D0, full_D1,
    input  pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1, data_out_arb,
    input  state, idle, error_arb, stall_count
  );
endinterface

// File: rtl/vc_arbiter.sv
// Weighted VC0/VC1 scheduler that routes each popped word to D0 or D1 by its destination bit.
// The optional blocked-cycle counter is built only when STALL_COUNT_EN is defined.
module vc_arbiter #(
  parameter int data_width = 6,
  parameter int DEST_BIT   = 4,
  parameter int VC0_WEIGHT = 3
) (
  input  logic         clk,
  input  logic         reset,
  vc_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } arb_state_e;

  localparam int                WCNT_W     = $clog2(VC0_WEIGHT + 1);
  localparam logic [WCNT_W-1:0] WEIGHT_MAX = WCNT_W'(VC0_WEIGHT);

  arb_state_e            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q;
  logic                  s1_valid_q;
  logic                  s1_vc1_q;
  logic                  push_d0_q, push_d1_q;
  logic [data_width-1:0] data_q;
  logic                  error_q;

  logic                  can_grant;
  logic                  grant_vc0, grant_vc1, grant_any;
  logic                  push_any;
  logic [data_width-1:0] word_s1;

  // VC1 preempts VC0 only after VC0 has used up its weight while VC1 is waiting.
  always_comb begin
    can_grant = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                !bus.almost_full_D0 && !bus.almost_full_D1;
    grant_vc0 = can_grant && !bus.empty_fifo_VC0 &&
                (bus.empty_fifo_VC1 || (wcnt_q < WEIGHT_MAX));
    grant_vc1 = can_grant && !grant_vc0 && !bus.empty_fifo_VC1;
    grant_any = grant_vc0 || grant_vc1;
    push_any  = push_d0_q || push_d1_q;
    word_s1   = s1_vc1_q ? bus.data_out_VC1 : bus.data_out_VC0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (grant_any) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!grant_any && !s1_valid_q && !push_any) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      wcnt_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_vc1_q   <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant_vc1 || bus.empty_fifo_VC1) begin
        wcnt_q <= '0;
      end else if (grant_vc0) begin
        wcnt_q <= wcnt_q + 1'b1;
      end

      // Stage 1 remembers which FIFO was popped; its read data arrives one cycle later.
      s1_valid_q <= grant_any;
      s1_vc1_q   <= grant_vc1;
      push_d0_q  <= s1_valid_q && !word_s1[DEST_BIT];
      push_d1_q  <= s1_valid_q &&  word_s1[DEST_BIT];
      if (s1_valid_q) begin
        data_q <= word_s1;
      end

      error_q <= error_q || (push_d0_q && bus.full_D0) || (push_d1_q && bus.full_D1);
    end
  end

  assign bus.pop_VC0_fifo = grant_vc0;
  assign bus.pop_VC1_fifo = grant_vc1;
  assign bus.push_D0      = push_d0_q;
  assign bus.push_D1      = push_d1_q;
  assign bus.data_out_arb = data_q;
  assign bus.state        = state_q;
  assign bus.idle         = (state_q == ST_IDLE);
  assign bus.error_arb    = error_q;

`ifdef STALL_COUNT_EN
  logic [7:0] stall_q;
  logic       stall_cond;

  assign stall_cond = ((state_q == ST_IDLE) || (state_q == ST_ACTIVE)) &&
                      (!bus.empty_fifo_VC0 || !bus.empty_fifo_VC1) &&
                      (bus.almost_full_D0 || bus.almost_full_D1);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 8'd0;
    end else if (stall_cond && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign bus.stall_count = stall_q;
`else
  assign bus.stall_count = 8'd0;
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: VC FIFO models, scoreboard of expected pushes, reset/backpressure/error cases.
module tb_vc_arbiter;
  localparam int DW = 6;

`ifdef STALL_COUNT_EN
  localparam int BLOCK_N   = 300;
  localparam int EXP_STALL = 255;
`else
  localparam int BLOCK_N   = 5;
  localparam int EXP_STALL = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  vc_arbiter_if #(.data_width(DW)) bus();

  vc_arbiter #(
    .data_width (DW),
    .DEST_BIT   (4),
    .VC0_WEIGHT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected push: {push_D1, push_D0, data_out_arb}
  logic [DW+1:0] exp_q[$];

  // ---------------- VC FIFO models ----------------
  logic [DW-1:0] vc0_mem [64];
  logic [DW-1:0] vc1_mem [64];
  int head0 = 0, tail0 = 0, head1 = 0, tail1 = 0;

  assign bus.empty_fifo_VC0 = (head0 == tail0);
  assign bus.empty_fifo_VC1 = (head1 == tail1);

  always @(posedge clk) begin
    if (bus.pop_VC0_fifo && (head0 != tail0)) begin
      bus.data_out_VC0 <= vc0_mem[head0 % 64];
      head0 <= head0 + 1;
    end
    if (bus.pop_VC1_fifo && (head1 != tail1)) begin
      bus.data_out_VC1 <= vc1_mem[head1 % 64];
      head1 <= head1 + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_vc0(input logic [DW-1:0] w);
    vc0_mem[tail0 % 64] = w;
    tail0++;
  endtask

  task automatic load_vc1(input logic [DW-1:0] w);
    vc1_mem[tail1 % 64] = w;
    tail1++;
  endtask

  // D1 when bit 4 is set, D0 otherwise
  task automatic expect_word(input logic [DW-1:0] w);
    if (w[4]) exp_q.push_back({2'b10, w});
    else      exp_q.push_back({2'b01, w});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (bus.push_D0 || bus.push_D1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL push_unexpected: got d1=%0b d0=%0b data=%0h expected no push at %0t",
                   bus.push_D1, bus.push_D0, bus.data_out_arb, $time);
        end else begin
          logic [DW+1:0] exp_v;
          logic [DW+1:0] got_v;
          exp_v = exp_q.pop_front();
          got_v = {bus.push_D1, bus.push_D0, bus.data_out_arb};
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL push_word: got %0h expected %0h at %0t", got_v, exp_v, $time);
          end
        end
      end
      if (bus.pop_VC0_fifo || bus.pop_VC1_fifo) begin
        checks++;
        if ((bus.pop_VC0_fifo && bus.empty_fifo_VC0) || (bus.pop_VC1_fifo && bus.empty_fifo_VC1) ||
            (bus.pop_VC0_fifo && bus.pop_VC1_fifo)) begin
          errors++;
          $display("FAIL pop_legal: got pop0=%0b pop1=%0b e0=%0b e1=%0b expected legal single pop at %0t",
                   bus.pop_VC0_fifo, bus.pop_VC1_fifo, bus.empty_fifo_VC0, bus.empty_fifo_VC1, $time);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic found;
    bus.almost_full_D0 = 1'b0;
    bus.almost_full_D1 = 1'b0;
    bus.full_D0        = 1'b0;
    bus.full_D1        = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", {bus.pop_VC0_fifo, bus.pop_VC1_fifo, bus.push_D0, bus.push_D1,
                          bus.data_out_arb, bus.idle, bus.error_arb, bus.stall_count}, 0);
    check("rst_state", bus.state, 0);

    // single VC0 word 6'h11 routed to D1; D0 full must not matter
    bus.full_D0 = 1'b1;
    load_vc0(6'h11);
    expect_word(6'h11);
    reset = 1'b0;
    @(negedge clk); #1;
    check("init_state", bus.state, 1);
    check("init_no_pop", bus.pop_VC0_fifo, 0);
    @(negedge clk); #1;
    check("idle_state", bus.state, 2);
    check("idle_flag", bus.idle, 1);
    check("pop_n", bus.pop_VC0_fifo, 1);
    @(negedge clk); #1;
    check("active_state", bus.state, 3);
    check("no_push_n1", {bus.push_D1, bus.push_D0}, 0);
    @(negedge clk); #1;
    check("push_d1_n2", bus.push_D1, 1);
    check("push_d0_n2", bus.push_D0, 0);
    check("data_n2", bus.data_out_arb, 6'h11);
    wait_drain("drain_single");
    check("no_err_other_full", bus.error_arb, 0);
    check("back_idle", bus.state, 2);
    bus.full_D0 = 1'b0;

    // weighted priority: VC0,VC0,VC0,VC1 then VC0 drains, VC1 last
    load_vc0(6'h01); load_vc0(6'h12); load_vc0(6'h23);
    load_vc0(6'h04); load_vc0(6'h35); load_vc0(6'h06);
    load_vc1(6'h2A); load_vc1(6'h1B);
    expect_word(6'h01); expect_word(6'h12); expect_word(6'h23); expect_word(6'h2A);
    expect_word(6'h04); expect_word(6'h35); expect_word(6'h06); expect_word(6'h1B);
    wait_drain("drain_weighted");

    // backpressure with two words in flight
    load_vc0(6'h10); load_vc0(6'h21); load_vc0(6'h02); load_vc0(6'h33);
    expect_word(6'h10); expect_word(6'h21); expect_word(6'h02); expect_word(6'h33);
    check("stall_before", bus.stall_count, 0);
    @(negedge clk);
    @(negedge clk);
    bus.almost_full_D0 = 1'b1;
    repeat (BLOCK_N) begin
      #1;
      if (bus.pop_VC0_fifo || bus.pop_VC1_fifo) begin
        check("af_blocks_pop", {bus.pop_VC1_fifo, bus.pop_VC0_fifo}, 0);
      end
      @(negedge clk);
    end
    #1;
    check("af_blocked_pops", {bus.pop_VC1_fifo, bus.pop_VC0_fifo}, 0);
    check("inflight_pushed", exp_q.size(), 2);
    check("stall_count", bus.stall_count, EXP_STALL);
    bus.almost_full_D0 = 1'b0;
    #1;
    check("af_release_pop", bus.pop_VC0_fifo, 1);
    wait_drain("drain_backpressure");

    // push into a full D1 sets sticky error
    check("err_clear", bus.error_arb, 0);
    bus.full_D1 = 1'b1;
    load_vc0(6'h15);
    expect_word(6'h15);
    found = 1'b0;
    for (int i = 0; (i < 10) && !found; i++) begin
      @(negedge clk); #1;
      if (bus.push_D1) found = 1'b1;
    end
    check("err_push_seen", found, 1);
    check("err_not_yet", bus.error_arb, 0);
    @(negedge clk); #1;
    check("err_set", bus.error_arb, 1);
    bus.full_D1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", bus.error_arb, 1);
    wait_drain("drain_error");

    // reset while streaming
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] w;
      w = DW'(6'h08 + 6'(i * 5));
      load_vc0(w);
      expect_word(w);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_pop", {bus.pop_VC1_fifo, bus.pop_VC0_fifo}, 0);
    check("midrst_push", {bus.push_D1, bus.push_D0}, 0);
    check("midrst_state", bus.state, 0);
    check("midrst_err", bus.error_arb, 0);
    exp_q.delete();
    tail0 = head0;
    tail1 = head1;
    reset = 1'b0;
    @(negedge clk); #1;
    check("rerst_init", bus.state, 1);
    repeat (10) @(negedge clk);
    #1;
    check("rerst_idle", bus.state, 2);

    // VC1 word to D0 after reset
    load_vc1(6'h2C);
    expect_word(6'h2C);
    wait_drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
